// File: rtl/sm_pc_trace.sv
// PC trace buffer: circular capture of the PC word, stopping a fixed
// number of samples after a breakpoint match, then frozen for readout.
module sm_pc_trace #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int POST_TRIG = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] pc,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              capturing,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] trig_idx
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] TAIL = (ADDR_W+1)'(POST_TRIG + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        POST,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] postCnt;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rdIdx;
    logic [ADDR_W:0]   countNext;
    logic              doWrite;
    logic              trigHit;
    logic              enterDone;
    logic              rdHit;

    always_comb begin
        stateNext = state;
        doWrite   = 1'b0;
        trigHit   = 1'b0;
        enterDone = 1'b0;
        if (count == FULL) begin
            countNext = count;
        end else begin
            countNext = count + 1'b1;
        end
        if (arm) begin
            stateNext = PRE;
        end else begin
            unique case (state)
                IDLE: ;
                PRE: begin
                    if (en) begin
                        doWrite = 1'b1;
                        if (trig_en && pc == trig_pc) begin
                            trigHit = 1'b1;
                            if (POST_TRIG == 0) begin
                                stateNext = DONE;
                                enterDone = 1'b1;
                            end else begin
                                stateNext = POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (en) begin
                        doWrite = 1'b1;
                        if (postCnt == ADDR_W'(1)) begin
                            stateNext = DONE;
                            enterDone = 1'b1;
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wrPtr    <= '0;
            count    <= '0;
            postCnt  <= '0;
            trig_idx <= '0;
        end else begin
            state <= stateNext;
            if (arm) begin
                wrPtr   <= '0;
                count   <= '0;
                postCnt <= '0;
            end else if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
                count <= countNext;
                if (trigHit) begin
                    postCnt <= ADDR_W'(POST_TRIG);
                end else if (state == POST) begin
                    postCnt <= postCnt - 1'b1;
                end
                if (enterDone) begin
                    trig_idx <= ADDR_W'(countNext - TAIL);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite && !arm) begin
            mem[wrPtr] <= pc;
        end
    end

    // once the ring is full the slot about to be overwritten is the oldest
    assign oldest = (count == FULL) ? wrPtr : '0;
    assign rdIdx  = oldest + rd_addr;
    assign rdHit  = {1'b0, rd_addr} < count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rdHit;
            if (rdHit) begin
                rd_data <= mem[rdIdx];
            end else begin
                rd_data <= '0;
            end
        end
    end

    assign capturing = (state == PRE) || (state == POST);
    assign done      = (state == DONE);

endmodule
